// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse / lock qualification sequencer
// Optional WAIT_LOCK timeout retry enabled by macro PLL_RETRY_TIMEOUT_EN.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_count,
    output logic [7:0] retry_count
);
    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_t;

`ifdef PLL_RETRY_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int BASE_MAX   = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYCLES = (TIMEOUT_EN && LOCK_TIMEOUT_CYCLES > BASE_MAX) ? LOCK_TIMEOUT_CYCLES : BASE_MAX;
    localparam int TW         = $clog2(MAX_CYCLES + 1);

    localparam logic [TW-1:0] RST_LAST = TW'(RST_PULSE_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle.
    localparam logic [TW-1:0] STB_LAST = TW'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);

    logic [1:0]    rst_sync;
    logic          run_en;
    logic          lock_meta;
    logic          lock_s;
    state_t        state_q;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic          timer_run;

    assign run_en = rst_sync[1];
    assign state  = state_q;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync  <= 2'b00;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

`ifdef PLL_RETRY_TIMEOUT_EN
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    logic       timeout_hit;
    logic [7:0] retry_q;

    assign timeout_hit = (state_q == WAIT_LOCK) && !lock_s && (timer == TO_LAST);
    assign retry_count = retry_q;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            retry_q <= 8'd0;
        end else if (timeout_hit && !restart && retry_q != 8'hFF) begin
            retry_q <= retry_q + 8'd1;
        end
    end
`else
    assign retry_count = 8'd0;
`endif

    always_comb begin
        next_state = state_q;
        case (state_q)
            RESET_PLL: if (run_en && timer == RST_LAST) next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = (LOCK_STABLE_CYCLES == 1) ? RUN : STABILIZE;
                end
`ifdef PLL_RETRY_TIMEOUT_EN
                else if (timeout_hit) begin
                    next_state = RESET_PLL;
                end
`endif
            end
            STABILIZE: begin
                if (!lock_s)                next_state = WAIT_LOCK;
                else if (timer == STB_LAST) next_state = RUN;
            end
            RUN:       if (!lock_s) next_state = RESET_PLL;
            default:   next_state = RESET_PLL;
        endcase
        if (restart) next_state = RESET_PLL;
    end

    always_comb begin
        timer_run = 1'b1;
        if (state_q == RUN) timer_run = 1'b0;
        if (state_q == WAIT_LOCK && !TIMEOUT_EN) timer_run = 1'b0;
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RESET_PLL;
            timer           <= '0;
            pll_rst         <= 1'b1;
            core_reset_n    <= 1'b0;
            ready           <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state_q      <= next_state;
            pll_rst      <= (next_state == RESET_PLL);
            core_reset_n <= (next_state == RUN);
            ready        <= (next_state == RUN);
            // Pulse timing only starts once the reset release has been synchronized.
            if (restart || next_state != state_q || (state_q == RESET_PLL && !run_en)) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + TW'(1);
            end
            if (state_q == RUN && !lock_s && lock_loss_count != 8'hFF) begin
                lock_loss_count <= lock_loss_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - randomized self-checking bench for pll_reset_sequencer
// Expectations follow PLL_RETRY_TIMEOUT_EN when it is defined for the build.
module tb_pll_reset_sequencer;
    localparam int RST = 4;
    localparam int STB = 8;
    localparam int TO  = 32;
`ifdef PLL_RETRY_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b1;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;
    logic [7:0] retry_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int m_state, m_cnt, m_consec, m_loss, m_retry;
    bit m_rs0, m_rs1, m_lk0, m_lk1;

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES(RST),
        .LOCK_STABLE_CYCLES(STB),
        .LOCK_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .restart(restart),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .core_reset_n(core_reset_n),
        .ready(ready),
        .state(state),
        .lock_loss_count(lock_loss_count),
        .retry_count(retry_count)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_consec = 0; m_loss = 0; m_retry = 0;
        m_rs0 = 0; m_rs1 = 0; m_lk0 = 0; m_lk1 = 0;
    endtask

    // One clock of the behavioural model: sync pipes, counts of cycles/consecutive locks.
    task automatic model_step();
        bit lk_s, en;
        int ns, consec_now;
        if (!reset_n) begin
            model_reset();
            return;
        end
        lk_s = m_lk1;
        en   = m_rs1;
        consec_now = (((m_state == 1) || (m_state == 2)) && lk_s) ? m_consec + 1 : 0;
        ns = m_state;
        case (m_state)
            0: if (en && m_cnt + 1 == RST) ns = 1;
            1: begin
                if (lk_s) ns = (consec_now >= STB) ? 3 : 2;
                else if (TIMEOUT_ON && m_cnt + 1 == TO) begin
                    ns = 0;
                    if (!restart && m_retry < 255) m_retry++;
                end
            end
            2: begin
                if (!lk_s) ns = 1;
                else if (consec_now >= STB) ns = 3;
            end
            default: if (!lk_s) ns = 0;
        endcase
        if (m_state == 3 && !lk_s && m_loss < 255) m_loss++;
        if (restart) ns = 0;
        if (ns != m_state || restart || (m_state == 0 && !en)) m_cnt = 0;
        else m_cnt++;
        m_consec = (ns == 1 || ns == 2) ? consec_now : 0;
        m_state = ns;
        m_rs1 = m_rs0; m_rs0 = 1'b1;
        m_lk1 = m_lk0; m_lk0 = pll_locked;
    endtask

    task automatic check_all();
        check("state", 32'(state), 32'(m_state));
        check("pll_rst", 32'(pll_rst), 32'(m_state == 0));
        check("core_reset_n", 32'(core_reset_n), 32'(m_state == 3));
        check("ready", 32'(ready), 32'(m_state == 3));
        check("lock_loss_count", 32'(lock_loss_count), 32'(m_loss));
        check("retry_count", 32'(retry_count), 32'(m_retry));
    endtask

    task automatic tick(input bit rs, input bit lk, input bit rn);
        @(negedge clk_74a);
        restart = rs; pll_locked = lk; reset_n = rn;
        if (!rn) begin
            model_reset();
            #1 check_all();
        end
        @(posedge clk_74a);
        model_step();
        cyc++;
        #1 check_all();
    endtask

    task automatic run_until_ready(output int lat);
        int lk_rise;
        bit prev;
        lat = -1;
        lk_rise = -1;
        for (int i = 0; i < 200; i++) begin
            prev = m_lk1;
            tick(1'b0, 1'b1, 1'b1);
            if (!prev && m_lk1) lk_rise = cyc;
            if (ready === 1'b1) begin
                lat = cyc - lk_rise;
                break;
            end
        end
    endtask

    initial begin
        int lat, rst_hi, loss_before;
        bit found;
        model_reset();
        #3 reset_n = 1'b0;
        #1 check_all();

        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
        run_until_ready(lat);
        check("lock_to_ready_latency", 32'(lat), 32'(STB));

        tick(1'b0, 1'b0, 1'b1);
        rst_hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (pll_rst === 1'b1) rst_hi++;
        end
        check("lock_loss_pulse_len", 32'(rst_hi), 32'(RST));
        check("lock_loss_once", 32'(lock_loss_count), 32'd1);

        tick(1'b1, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (m_state == 2 && m_consec == 5) found = 1'b1;
        end
        check("glitch_reach_stabilize", 32'(found), 32'd1);
        tick(1'b0, 1'b0, 1'b1);
        run_until_ready(lat);
        check("relock_latency", 32'(lat), 32'(STB));

        loss_before = m_loss;
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        check("restart_with_loss_state", 32'(state), 32'd0);
        check("restart_with_loss_count", 32'(lock_loss_count), 32'(loss_before + 1));

        for (int i = 0; i < 256 * (RST + TO) + 60; i++) tick(1'b0, 1'b0, 1'b1);
        check("retry_saturated", 32'(retry_count), TIMEOUT_ON ? 32'd255 : 32'd0);

        tick(1'b1, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            if (m_state == 2 && m_consec == 3) found = 1'b1;
        end
        check("reach_stabilize", 32'(found), 32'd1);
        tick(1'b0, 1'b1, 1'b0);
        check("abort_pll_rst", 32'(pll_rst), 32'd1);
        check("abort_loss_cleared", 32'(lock_loss_count), 32'd0);
        tick(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 499) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 16, cycles pll_rst is held high per reset pulse (min 1).
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, consecutive synchronized-lock cycles required before release (min 1).
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000, cycles allowed in WAIT_LOCK before retry (min 1).
REQ-004 SHALL have port clk_74a  input  1  sole clock, 74.25 MHz reference domain.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port restart  input  1  single-cycle request to re-sequence the PLL.
REQ-007 SHALL have port pll_locked  input  1  PLL locked flag, asynchronous to clk_74a.
REQ-008 SHALL have port pll_rst  output  1  active-high reset driven to the PLL.
REQ-009 SHALL have port core_reset_n  output  1  active-low reset for logic on PLL output clocks.
REQ-010 SHALL have port ready  output  1  high only in RUN.
REQ-011 SHALL have port state  output  2  current state encoding.
REQ-012 SHALL have port lock_loss_count  output  8  saturating count of lock losses in RUN.
REQ-013 SHALL have port retry_count  output  8  saturating count of timeout retries.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; all decisions use the synchronized value (lock_s), 2-cycle latency.
REQ-015 SHALL implement states RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3; state output equals encoding.
REQ-016 RESET_PLL: pll_rst=1; after exactly RST_PULSE_CYCLES cycles in state, go to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABILIZE; timer reaching LOCK_TIMEOUT_CYCLES with lock_s=0 -> per REQ-029/030.
REQ-018 STABILIZE: counts consecutive lock_s=1 cycles; lock_s=0 -> WAIT_LOCK (timeout timer restarted); count reaching LOCK_STABLE_CYCLES -> RUN.
REQ-019 RUN: ready=1, core_reset_n=1; lock_s=0 -> RESET_PLL and lock_loss_count increments.
REQ-020 core_reset_n SHALL be 0 in every state except RUN; pll_rst, core_reset_n, ready SHALL be registered outputs.
REQ-021 restart=1 in any state SHALL force RESET_PLL next cycle with cycle counter cleared; restart has priority over all other transitions.
REQ-022 restart and lock loss in the same RUN cycle: go to RESET_PLL and still increment lock_loss_count.
REQ-023 Counters SHALL saturate at 255, never wrap; only reset_n clears them (restart does not).
REQ-024 Single shared cycle timer SHALL be cleared on every state entry, sized ceil(log2(max parameter+1)) bits.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=RESET_PLL, pll_rst=1, core_reset_n=0, ready=0, counters=0, timer=0, synchronizer=0.
REQ-026 reset_n deassertion SHALL be synchronized internally (2-flop) before the FSM leaves RESET_PLL.
REQ-027 reset_n asserted mid-sequence (any state) SHALL abort immediately; the full RST_PULSE_CYCLES pulse restarts after release.

Configuration
REQ-028 Macro PLL_RETRY_TIMEOUT_EN SHALL select lock-timeout retry behaviour.
REQ-029 With PLL_RETRY_TIMEOUT_EN defined: WAIT_LOCK timeout -> RESET_PLL, retry_count increments (saturating).
REQ-030 Without it: WAIT_LOCK waits indefinitely, no timeout timer logic, retry_count tied to 0.

Verification (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-031 Release reset_n, pll_locked=1 at cycle 10 -> pll_rst high 4 cycles, ready rises exactly 8 cycles after lock_s=1, core_reset_n=1 same cycle.
REQ-032 In RUN, drop pll_locked 1 cycle -> RESET_PLL 2 cycles later, ready=0, lock_loss_count=1, pll_rst pulse of 4 cycles.
REQ-033 pll_locked glitch low at STABILIZE count 5 -> back to WAIT_LOCK, RUN reached only after 8 new consecutive lock cycles.
REQ-034 Macro defined, pll_locked held 0 -> pll_rst re-pulses every 4+32 cycles, retry_count increments each time, saturates at 255; macro undefined -> single pulse, retry_count=0.
REQ-035 restart pulse in RUN together with lock loss -> RESET_PLL next cycle, lock_loss_count+1; reset_n pulsed in STABILIZE -> all outputs at reset values immediately.
